// File: rtl/cond_seq_pkg.sv
// rtl/cond_seq_pkg.sv - shared state encoding and default widths for the condition sequencer
package cond_seq_pkg;

  localparam int DEF_DELAY_W = 16;
  localparam int DEF_ERR_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PH0,
    ST_PH1,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cond_seq_checker.sv
// rtl/cond_seq_checker.sv - compares DUT responses against condition delayed one cycle
module cond_seq_checker
  import cond_seq_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             condition,
  input  logic             arm_in,
  input  logic             resp_a,
  input  logic             resp_b,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] err_count_next
);

  logic             exp_q, exp_d;
  logic             arm_q, arm_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             mismatch;

  always_comb begin
    exp_d       = condition;
    arm_d       = arm_in;
    mismatch    = arm_q && ((resp_a != exp_q) || (resp_b != exp_q));
    err_count_d = err_count_q;
    if (clr) begin
      err_count_d = '0;
    end else if (mismatch && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q       <= 1'b0;
      arm_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      exp_q       <= exp_d;
      arm_q       <= arm_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count      = err_count_q;
  assign err_count_next = err_count_d;

endmodule

// File: rtl/cond_sequencer.sv
// rtl/cond_sequencer.sv - two-phase condition stimulus generator with response checking
module cond_sequencer
  import cond_seq_pkg::*;
#(
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DELAY_W-1:0] cfg_pre,
  input  logic [DELAY_W-1:0] cfg_hold,
  input  logic               cfg_first,
  input  logic               resp_a,
  input  logic               resp_b,
  output logic               condition,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count
);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] hold_q, hold_d;
  logic               first_q, first_d;
  logic               condition_q, condition_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               clr;
  logic               arm;
  logic [ERR_W-1:0]   err_next;

  // A length of zero behaves as one, so the terminal count is max(v,1)-1.
  function automatic logic [DELAY_W-1:0] load_val(input logic [DELAY_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    first_d = first_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRE;
          cnt_d   = load_val(cfg_pre);
          hold_d  = load_val(cfg_hold);
          first_d = cfg_first;
          pass_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt_q == '0) begin
          state_d = ST_PH0;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PH0: begin
        if (cnt_q == '0) begin
          state_d = ST_PH1;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PH1: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // The final PH1 response is compared during DONE, so pass includes it.
        state_d = ST_IDLE;
        pass_d  = (err_next == '0);
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered against the next state so they line up with state_q.
    condition_d = 1'b0;
    if (state_d == ST_PH0) condition_d = first_d;
    if (state_d == ST_PH1) condition_d = ~first_d;
    busy_d = (state_d == ST_PRE) || (state_d == ST_PH0) || (state_d == ST_PH1);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      first_q     <= 1'b0;
      condition_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      first_q     <= first_d;
      condition_q <= condition_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign arm = (state_q == ST_PH0) || (state_q == ST_PH1);

  cond_seq_checker #(
    .ERR_W(ERR_W)
  ) u_checker (
    .clk           (clk),
    .reset         (reset),
    .clr           (clr),
    .condition     (condition_q),
    .arm_in        (arm),
    .resp_a        (resp_a),
    .resp_b        (resp_b),
    .err_count     (err_count),
    .err_count_next(err_next)
  );

  assign condition = condition_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_cond_sequencer.sv
// tb/tb_cond_sequencer.sv - randomized and directed checks of cond_sequencer against a timeline model
module tb_cond_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_pre = '0;
  logic [15:0] cfg_hold = '0;
  logic        cfg_first = 1'b0;
  logic        resp_a = 1'b0, resp_b = 1'b0;
  logic        resp_a2 = 1'b0, resp_b2 = 1'b0;
  logic        condition, busy, done, pass;
  logic [7:0]  err_count;
  logic        condition2, busy2, done2, pass2;
  logic [1:0]  err_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_sequencer #(.DELAY_W(16), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_pre(cfg_pre), .cfg_hold(cfg_hold),
    .cfg_first(cfg_first), .resp_a(resp_a), .resp_b(resp_b), .condition(condition),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  cond_sequencer #(.DELAY_W(16), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .cfg_pre(cfg_pre), .cfg_hold(cfg_hold),
    .cfg_first(cfg_first), .resp_a(resp_a2), .resp_b(resp_b2), .condition(condition2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected condition in cycle k after the start cycle (k=0): P idle, H first, H inverted.
  function automatic bit exp_cond(input int k, input int pe, input int he, input bit first);
    if (k <= pe) return 1'b0;
    if (k <= pe + he) return first;
    if (k <= pe + 2 * he) return ~first;
    return 1'b0;
  endfunction

  // mode: 0 ideal DUT, 1 resp_b stuck 0, 2 resp_a inverted, 3 random bit flips.
  task automatic run(input int p, input int h, input bit first, input int mode,
                     input int spur_k, input int rst_k);
    int   pe, he, last, exp_err, exp_err2;
    logic prev1, prev2;
    bit   fa, fb, c;
    pe = (p == 0) ? 1 : p;
    he = (h == 0) ? 1 : h;
    last = pe + 2 * he + 2;
    exp_err = 0;
    exp_err2 = (mode == 2) ? ((2 * he > 3) ? 3 : 2 * he) : 0;
    @(negedge clk);
    start = 1'b1;
    cfg_pre = 16'(p);
    cfg_hold = 16'(h);
    cfg_first = first;
    prev1 = condition;
    prev2 = condition2;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start = (k == spur_k);
      cfg_pre = 16'($urandom_range(0, 9));
      cfg_hold = 16'($urandom_range(0, 9));
      cfg_first = 1'($urandom);
      if (rst_k > 0 && k == rst_k + 1) begin
        check("rst_cond", condition, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_count, 0);
        check("rst_pass", pass, 0);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("post_rst_done", done, 0);
          check("post_rst_busy", busy, 0);
        end
        return;
      end
      check("cond", condition, exp_cond(k, pe, he, first));
      check("busy", busy, (k <= pe + 2 * he) ? 1 : 0);
      check("done", done, (k == pe + 2 * he + 1) ? 1 : 0);
      check("cond2", condition2, exp_cond(k, pe, he, first));
      if (k == 1) begin
        check("err_clr", err_count, 0);
        check("pass_clr", pass, 0);
      end
      if (k == last) begin
        check("err_count", err_count, (exp_err > 255) ? 255 : exp_err);
        check("pass", pass, (exp_err == 0) ? 1 : 0);
        check("err_count_sat", err_count2, exp_err2);
        check("pass2", pass2, (exp_err2 == 0) ? 1 : 0);
      end
      fa = (mode == 2) ? 1'b1 : (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
      fb = (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
      resp_a = prev1 ^ fa;
      resp_b = (mode == 1) ? 1'b0 : (prev1 ^ fb);
      resp_a2 = prev2 ^ (mode == 2);
      resp_b2 = prev2;
      c = exp_cond(k - 1, pe, he, first);
      if (k >= pe + 2 && k <= pe + 2 * he + 1 && (fa || ((mode == 1) ? c : fb)))
        exp_err++;
      prev1 = condition;
      prev2 = condition2;
      if (k == rst_k) reset = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_cond", condition, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_count, 0);
    check("reset_pass", pass, 0);

    run(3, 10, 1'b0, 0, -1, -1);
    run(3, 10, 1'b0, 1, -1, -1);
    run(0, 0, 1'b1, 0, -1, -1);
    run(2, 8, 1'b1, 2, -1, -1);
    run(3, 10, 1'b0, 0, 6, 16);
    run(2, 3, 1'b1, 0, 9, -1);
    run(200, 150, 1'b0, 2, 5, -1);

    for (int i = 0; i < 16; i++) begin
      int p, h, m;
      p = $urandom_range(0, 6);
      h = $urandom_range(0, 6);
      m = $urandom_range(0, 3);
      run(p, h, 1'($urandom), m,
          $urandom_range(2, ((p == 0) ? 1 : p) + 2 * ((h == 0) ? 1 : h) + 1), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
